// File: rtl/lcd_buf_arbiter.sv
// Two-requester round-robin write arbiter for a 32-character LCD display buffer,
// with a registered read port and a 32-cycle buffer clear sequence.
module lcd_buf_arbiter #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sel,
    output logic [7:0] dd_data,
    input  logic       req0,
    input  logic       req1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [7:0] char0,
    input  logic [7:0] char1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       clr,
    output logic       busy
);

    localparam logic StIdle  = 1'b0;
    localparam logic StClear = 1'b1;

    logic       state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [7:0] buf_q [32];
    logic [7:0] dd_data_q;
    logic       arb_en;

    // Grants are gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        arb_en = rst_n && (state_q == StIdle) && !clr;
        gnt0   = arb_en && req0 && (!req1 || last_q);
        gnt1   = arb_en && req1 && (!req0 || !last_q);
        busy   = (state_q == StClear);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (state_q == StClear) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d = StIdle;
            end
        end else if (clr) begin
            state_d = StClear;
            cnt_d   = 5'd0;
        end else if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= FILL_CHAR;
            end
        end else if (state_q == StClear) begin
            buf_q[cnt_q] <= FILL_CHAR;
        end else if (gnt0) begin
            buf_q[addr0] <= char0;
        end else if (gnt1) begin
            buf_q[addr1] <= char1;
        end
    end

    // Read samples the pre-write contents, so same-cycle writes show up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dd_data_q <= FILL_CHAR;
        end else begin
            dd_data_q <= buf_q[sel];
        end
    end

    assign dd_data = dd_data_q;

endmodule
